// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: accepts read/write burst commands and runs one
// handshaked memory access per beat. Optional MEM_BURST_CHECKSUM_EN adds a running XOR checksum.
module mem_burst_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int ADDR  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [ADDR-1:0]  cmd_addr,
   input  logic [ADDR:0]    cmd_len,
   input  logic             wd_valid,
   input  logic [WIDTH-1:0] wd_data,
   output logic             wd_ready,
   output logic             m_valid,
   output logic             m_wrbar,
   output logic [ADDR-1:0]  m_addr,
   output logic [WIDTH-1:0] m_wdata,
   input  logic [WIDTH-1:0] m_rdata,
   input  logic             m_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] csum
);

   localparam int LEN_W = ADDR + 1;

   typedef enum logic [1:0] {IDLE, FETCH, REQ, DONE} state_t;

   state_t           state, state_nxt;
   logic [ADDR-1:0]  addr_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat_q;
   logic             op_q;

   logic legal, accept, beat_hs, wd_hs, last_beat;

   assign legal     = (cmd_len != '0) && (cmd_len <= LEN_W'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;
   assign beat_hs   = m_valid && m_ready;
   assign wd_hs     = wd_valid && wd_ready;
   assign last_beat = (beat_q + LEN_W'(1)) == len_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: next state defaults to the current state so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept && legal) state_nxt = cmd_wr ? FETCH : REQ;
         FETCH: if (wd_valid)        state_nxt = REQ;
         REQ: begin
            if (beat_hs) begin
               if (last_beat) state_nxt = DONE;
               else           state_nxt = op_q ? FETCH : REQ;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cmd_ready is gated by rst so it reads 0 while reset is held.
   always_comb begin
      cmd_ready = 1'b0;
      wd_ready  = 1'b0;
      case (state)
         IDLE:    cmd_ready = rst;
         FETCH:   wd_ready  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         op_q     <= 1'b0;
         m_valid  <= 1'b0;
         m_wrbar  <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done     <= (state == DONE);
         err      <= accept && !legal;
         rd_valid <= beat_hs && !op_q;
         if (beat_hs && !op_q) rd_data <= m_rdata;

         if (accept && legal) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            op_q   <= cmd_wr;
            beat_q <= '0;
         end

         if (wd_hs) m_wdata <= wd_data;

         // Request is raised one cycle after entering REQ, which also gives the
         // idle gap between consecutive read beats; fields then hold until m_ready.
         if (state == REQ && !m_valid) begin
            m_valid <= 1'b1;
            m_wrbar <= op_q;
            m_addr  <= addr_q + beat_q[ADDR-1:0];
         end else if (beat_hs) begin
            m_valid <= 1'b0;
            beat_q  <= beat_q + LEN_W'(1);
         end
      end
   end

`ifdef MEM_BURST_CHECKSUM_EN
   logic [WIDTH-1:0] csum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  csum_q <= '0;
      else if (accept)           csum_q <= '0;
      else if (wd_hs)            csum_q <= csum_q ^ wd_data;
      else if (beat_hs && !op_q) csum_q <= csum_q ^ m_rdata;
   end

   assign csum = csum_q;
`else
   assign csum = '0;
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a behavioural memory
// that can stretch m_ready by a programmable number of wait cycles.
module tb_mem_burst_ctrl;

   localparam int WIDTH = 32;
   localparam int DEPTH = 256;
   localparam int ADDR  = 8;
`ifdef MEM_BURST_CHECKSUM_EN
   localparam logic [WIDTH-1:0] EXP_CSUM = 32'h7;
`else
   localparam logic [WIDTH-1:0] EXP_CSUM = 32'h0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready, cmd_wr;
   logic [ADDR-1:0]  cmd_addr;
   logic [ADDR:0]    cmd_len;
   logic             wd_valid, wd_ready;
   logic [WIDTH-1:0] wd_data;
   logic             m_valid, m_wrbar, m_ready;
   logic [ADDR-1:0]  m_addr;
   logic [WIDTH-1:0] m_wdata, m_rdata;
   logic             rd_valid, done, err;
   logic [WIDTH-1:0] rd_data, csum;

   mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
      .m_valid(m_valid), .m_wrbar(m_wrbar), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .csum(csum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory model and logs
   logic [WIDTH-1:0] mem [DEPTH];
   int               ready_delay = 0;
   int               wait_cnt = 0;
   int               cyc = 0;
   logic [ADDR-1:0]  a_addr [$];
   logic             a_wr   [$];
   logic [WIDTH-1:0] a_wd   [$];
   logic [WIDTH-1:0] rd_q   [$];

   // write-data source
   logic [WIDTH-1:0] wd_buf [64];
   int               wd_taken = 0;
   int               wd_base = 0;
   int               wd_cnt = 0;
   logic             wd_en = 1'b0;
   int               wd_idx;

   assign wd_idx   = wd_taken - wd_base;
   assign wd_data  = wd_buf[wd_idx[5:0]];
   assign wd_valid = wd_en && (wd_idx < wd_cnt);
   assign m_ready  = m_valid && (wait_cnt >= ready_delay);
   assign m_rdata  = mem[m_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_valid && !m_ready) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (m_valid && m_ready) begin
         a_addr.push_back(m_addr);
         a_wr.push_back(m_wrbar);
         a_wd.push_back(m_wdata);
         if (m_wrbar) mem[m_addr] <= m_wdata;
      end
      if (wd_valid && wd_ready) wd_taken <= wd_taken + 1;
   end

   // negedge monitor: event counters, latency stamps, request stability
   int               done_cnt = 0, err_cnt = 0, mv_cnt = 0, stab_err = 0;
   int               acc_cyc = 0, done_cyc = 0;
   logic [WIDTH-1:0] csum_done = '0;
   logic             prev_mv = 1'b0, prev_hs = 1'b0, p_wr = 1'b0;
   logic [ADDR-1:0]  p_addr = '0;
   logic [WIDTH-1:0] p_wd = '0;

   always @(negedge clk) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         csum_done = csum;
      end
      if (err)      err_cnt++;
      if (m_valid)  mv_cnt++;
      if (rd_valid) rd_q.push_back(rd_data);
      if (!rst) begin
         prev_mv = 1'b0;
      end else begin
         if (prev_mv && !prev_hs &&
             (!m_valid || m_addr != p_addr || m_wdata != p_wd || m_wrbar != p_wr))
            stab_err++;
         prev_mv = m_valid;
         prev_hs = m_valid && m_ready;
         p_addr  = m_addr;
         p_wd    = m_wdata;
         p_wr    = m_wrbar;
      end
   end

   function automatic logic [WIDTH-1:0] pat(input int i);
      return 32'hA5A5_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   task automatic run_cmd(input logic wr, input logic [ADDR-1:0] a, input logic [ADDR:0] l);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_len   = l;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, wd_ready, m_valid, m_wrbar, rd_valid, done, err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {cmd_ready, wd_ready, m_valid, m_wrbar, rd_valid, done, err});
      end
      checks++;
      if ({m_addr, m_wdata, rd_data, csum} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%0h wdata=%0h rd=%0h csum=%0h expected all 0",
                  m_addr, m_wdata, rd_data, csum);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_write_burst();
      int b, d0, e0, n;
      bit ok;
      for (int i = 0; i < 32; i++) wd_buf[i] = pat(i);
      wd_base = wd_taken; wd_cnt = 32; wd_en = 1'b1;
      b = a_addr.size(); d0 = done_cnt; e0 = err_cnt;
      run_cmd(1'b1, 8'd0, 9'd32);
      wait_done(300, ok);
      wd_en = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL write_done_timeout: no done within budget"); end
      n = a_addr.size() - b;
      checks++;
      if (n != 32) begin errors++; $display("FAIL write_count: got %0d expected 32", n); end
      for (int i = 0; i < n && i < 32; i++) begin
         checks++;
         if (a_addr[b+i] !== 8'(i) || a_wd[b+i] !== pat(i) || a_wr[b+i] !== 1'b1) begin
            errors++;
            $display("FAIL write_beat%0d: addr=%0d data=%h wr=%b expected addr=%0d data=%h wr=1",
                     i, a_addr[b+i], a_wd[b+i], a_wr[b+i], i, pat(i));
         end
      end
      checks++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
         errors++;
         $display("FAIL write_done_err: done=%0d err=%0d expected done=1 err=0",
                  done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_read_burst();
      int b, r, n;
      bit ok;
      b = a_addr.size(); r = rd_q.size();
      run_cmd(1'b0, 8'd0, 9'd32);
      wait_done(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL read_done_timeout: no done within budget"); end
      n = rd_q.size() - r;
      checks++;
      if (n != 32) begin errors++; $display("FAIL read_strobes: got %0d expected 32", n); end
      for (int i = 0; i < n && i < 32; i++) begin
         checks++;
         if (rd_q[r+i] !== pat(i) || a_wr[b+i] !== 1'b0) begin
            errors++;
            $display("FAIL read_word%0d: data=%h wr=%b expected data=%h wr=0",
                     i, rd_q[r+i], a_wr[b+i], pat(i));
         end
      end
      checks++;
      if (done_cyc - acc_cyc != 65) begin
         errors++;
         $display("FAIL read_latency: got %0d cycles expected 65", done_cyc - acc_cyc);
      end
   endtask

   task automatic test_wrap();
      int b, r;
      bit ok;
      for (int i = 0; i < 10; i++) wd_buf[i] = pat(100 + i);
      wd_base = wd_taken; wd_cnt = 10; wd_en = 1'b1;
      run_cmd(1'b1, 8'd250, 9'd10);
      wait_done(300, ok);
      wd_en = 1'b0;
      b = a_addr.size(); r = rd_q.size();
      run_cmd(1'b0, 8'd250, 9'd10);
      wait_done(300, ok);
      checks++;
      if (!ok || a_addr.size() - b != 10 || rd_q.size() - r != 10) begin
         errors++;
         $display("FAIL wrap_count: done=%0d accesses=%0d strobes=%0d expected 1/10/10",
                  ok, a_addr.size() - b, rd_q.size() - r);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (a_addr[b+i] !== 8'((250 + i) % 256) || rd_q[r+i] !== pat(100 + i)) begin
            errors++;
            $display("FAIL wrap_beat%0d: addr=%0d data=%h expected addr=%0d data=%h",
                     i, a_addr[b+i], rd_q[r+i], (250 + i) % 256, pat(100 + i));
         end
      end
   endtask

   task automatic test_ready_delay();
      int b, m0, s0;
      bit ok;
      wd_buf[0] = 32'h1; wd_buf[1] = 32'h2; wd_buf[2] = 32'h4;
      wd_base = wd_taken; wd_cnt = 3; wd_en = 1'b1;
      ready_delay = 3;
      b = a_addr.size(); m0 = mv_cnt; s0 = stab_err;
      run_cmd(1'b1, 8'd100, 9'd3);
      wait_done(300, ok);
      wd_en = 1'b0;
      ready_delay = 0;
      checks++;
      if (!ok || a_addr.size() - b != 3) begin
         errors++;
         $display("FAIL delay_count: done=%0d accesses=%0d expected 1/3", ok, a_addr.size() - b);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (a_addr[b+i] !== 8'(100 + i) || a_wd[b+i] !== (32'h1 << i)) begin
            errors++;
            $display("FAIL delay_beat%0d: addr=%0d data=%h expected addr=%0d data=%h",
                     i, a_addr[b+i], a_wd[b+i], 100 + i, 32'h1 << i);
         end
      end
      checks++;
      if (stab_err != s0) begin
         errors++;
         $display("FAIL delay_stable: %0d unstable request cycles expected 0", stab_err - s0);
      end
      checks++;
      if (mv_cnt - m0 != 12) begin
         errors++;
         $display("FAIL delay_valid_cycles: got %0d expected 12", mv_cnt - m0);
      end
      checks++;
      if (csum_done !== EXP_CSUM || csum !== EXP_CSUM) begin
         errors++;
         $display("FAIL csum: at_done=%h now=%h expected %h", csum_done, csum, EXP_CSUM);
      end
   endtask

   task automatic test_illegal();
      logic [ADDR:0] lens [2];
      int e0, m0, d0;
      lens[0] = 9'd0; lens[1] = 9'd257;
      for (int k = 0; k < 2; k++) begin
         e0 = err_cnt; m0 = mv_cnt; d0 = done_cnt;
         run_cmd(1'b0, 8'd5, lens[k]);
         repeat (5) @(negedge clk);
         checks++;
         if (err_cnt - e0 != 1 || mv_cnt != m0 || done_cnt != d0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_len%0d: err=%0d mvalid=%0d done=%0d ready=%b expected 1/0/0/1",
                     lens[k], err_cnt - e0, mv_cnt - m0, done_cnt - d0, cmd_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      int r;
      bit ok1, ok2;
      r = rd_q.size();
      run_cmd(1'b0, 8'd10, 9'd2);
      wait_done(100, ok1);
      checks++;
      if (!ok1 || done_cyc - acc_cyc != 5) begin
         errors++;
         $display("FAIL b2b_latency: done=%0d cycles=%0d expected 1/5", ok1, done_cyc - acc_cyc);
      end
      run_cmd(1'b0, 8'd20, 9'd1);
      wait_done(100, ok2);
      checks++;
      if (!ok2 || rd_q.size() - r != 3 || rd_q[r] !== pat(10) || rd_q[r+1] !== pat(11)
          || rd_q[r+2] !== pat(20)) begin
         errors++;
         $display("FAIL b2b_data: done=%0d strobes=%0d expected 1/3 with pat(10),pat(11),pat(20)",
                  ok2, rd_q.size() - r);
      end
   endtask

   task automatic test_reset_mid_burst();
      int d0;
      run_cmd(1'b0, 8'd40, 9'd20);
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, wd_ready, m_valid, m_wrbar, rd_valid, done, err} !== 7'b0
          || {m_addr, m_wdata, rd_data, csum} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: flags=%b addr=%0h rd=%0h expected all 0",
                  {cmd_ready, wd_ready, m_valid, m_wrbar, rd_valid, done, err}, m_addr, rd_data);
      end
      d0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: got %b expected 1", cmd_ready);
      end
      repeat (60) @(negedge clk);
      checks++;
      if (done_cnt != d0 || mv_cnt < 0) begin
         errors++;
         $display("FAIL midreset_no_done: got %0d done pulses expected 0", done_cnt - d0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap();
      test_ready_delay();
      test_illegal();
      test_back_to_back();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
